// File: rtl/serial_comparator.sv
// serial_comparator: bit-serial, MSB-first magnitude comparator with start/busy/done handshake.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN finishes as soon as the first differing bit is seen.
module serial_comparator #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             busy,
   output logic             done,
   output logic [1:0]       out,
   output logic [WIDTH-1:0] x
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sa, sb;
   logic [WIDTH-1:0] wmask, wmask_nx;
   logic [1:0]       wres, wres_nx;
   logic             decided, decided_nx;
   logic [CW-1:0]    cnt;
   logic             a, b;

   assign a = sa[WIDTH-1];
   assign b = sb[WIDTH-1];

   always_comb begin
      state_nx   = state;
      wres_nx    = wres;
      wmask_nx   = wmask;
      decided_nx = decided;
      case (state)
         IDLE: begin
            if (start) state_nx = SHIFT;
         end
         SHIFT: begin
            wmask_nx[cnt] = ~(a ^ b);
            if (!decided && (a != b)) begin
               wres_nx    = a ? 2'b01 : 2'b10;
               decided_nx = 1'b1;
            end
            if (cnt == '0) state_nx = DONE;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
            if (!decided && (a != b)) state_nx = DONE;
`endif
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa      <= '0;
         sb      <= '0;
         wmask   <= '0;
         wres    <= '0;
         decided <= 1'b0;
         cnt     <= '0;
         out     <= '0;
         x       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sa      <= in1;
                  sb      <= in2;
                  decided <= 1'b0;
                  wres    <= '0;
                  wmask   <= '0;
                  cnt     <= CNT_LAST;
               end
            end
            SHIFT: begin
               sa      <= {sa[WIDTH-2:0], 1'b0};
               sb      <= {sb[WIDTH-2:0], 1'b0};
               decided <= decided_nx;
               wres    <= wres_nx;
               wmask   <= wmask_nx;
               if (cnt != '0) cnt <= cnt - CW'(1);
               // Results load on the edge entering DONE so out/x are valid alongside done.
               if (state_nx == DONE) begin
                  out <= wres_nx;
                  x   <= wmask_nx;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_comparator.sv
// Self-checking bench for serial_comparator against an arithmetic reference model.
module tb_serial_comparator;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] in1 = '0;
   logic [W-1:0] in2 = '0;
   logic         busy, done;
   logic [1:0]   out;
   logic [W-1:0] x;

   int total = 0;
   int bad   = 0;

   serial_comparator #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .in1   (in1),
      .in2   (in2),
      .busy  (busy),
      .done  (done),
      .out   (out),
      .x     (x)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] m_out(input logic [W-1:0] a, input logic [W-1:0] b);
      if (a > b) return 2'b01;
      if (a < b) return 2'b10;
      return 2'b00;
   endfunction

   function automatic int m_msbdiff(input logic [W-1:0] a, input logic [W-1:0] b);
      int p = -1;
      for (int i = 0; i < W; i++) if (a[i] != b[i]) p = i;
      return p;
   endfunction

   function automatic logic [W-1:0] m_x(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] m;
      m = ~(a ^ b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      if (a != b) begin
         int p = m_msbdiff(a, b);
         for (int i = 0; i < W; i++) if (i <= p) m[i] = 1'b0;
      end
`endif
      return m;
   endfunction

   function automatic int m_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      if (a != b) return (W - 1 - m_msbdiff(a, b)) + 2;
`endif
      return W + 1;
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string nm,
                         input bit wiggle);
      int lat = 0;
      int nbusy = 0;
      logic [1:0]   eo;
      logic [W-1:0] ex;
      eo = m_out(a, b);
      ex = m_x(a, b);
      @(negedge clk);
      in1 = a; in2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (wiggle) begin
         in1 = W'($urandom);
         in2 = W'($urandom);
      end
      for (int n = 1; n <= 40; n++) begin
         if (n > 1) @(negedge clk);
         if (busy) nbusy++;
         if (done) begin
            lat = n;
            break;
         end
      end
      total++;
      if (lat == 0) begin
         bad++;
         $display("FAIL %s timeout: no done within 40 cycles, need latency %0d", nm, m_lat(a, b));
         return;
      end
      if (lat !== m_lat(a, b)) begin
         bad++;
         $display("FAIL %s latency: got %0d need %0d", nm, lat, m_lat(a, b));
      end
      total++;
      if (out !== eo) begin
         bad++;
         $display("FAIL %s out: got %b need %b (a=%h b=%h)", nm, out, eo, a, b);
      end
      total++;
      if (x !== ex) begin
         bad++;
         $display("FAIL %s x: got %b need %b (a=%h b=%h)", nm, x, ex, a, b);
      end
      total++;
      if (nbusy !== m_lat(a, b)) begin
         bad++;
         $display("FAIL %s busy_cycles: got %0d need %0d", nm, nbusy, m_lat(a, b));
      end
      @(negedge clk);
      total++;
      if ({busy, done, out, x} !== {1'b0, 1'b0, eo, ex}) begin
         bad++;
         $display("FAIL %s hold: got busy=%b done=%b out=%b x=%b need 0 0 %b %b",
                  nm, busy, done, out, x, eo, ex);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({busy, done, out, x} !== '0) begin
         bad++;
         $display("FAIL reset_state: got busy=%b done=%b out=%b x=%b need all 0", busy, done, out, x);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({busy, done, out, x} !== '0) begin
         bad++;
         $display("FAIL reset_idle: got busy=%b done=%b out=%b x=%b need all 0", busy, done, out, x);
      end
   endtask

   task automatic test_basic();
      run_op(4'h2, 4'h1, "gt_2_1", 1'b0);
      run_op(4'h1, 4'h3, "lt_1_3", 1'b0);
      run_op(4'h4, 4'h4, "eq_4_4", 1'b0);
      run_op(4'hf, 4'h0, "gt_f_0", 1'b0);
      run_op(4'h0, 4'h1, "lt_0_1", 1'b0);
      run_op(4'h0, 4'h0, "eq_0_0", 1'b0);
   endtask

   task automatic test_ignored_start();
      int ndone = 0;
      int lat = 0;
      logic [1:0]   so = '0;
      logic [W-1:0] sx = '0;
      @(negedge clk);
      in1 = 4'ha; in2 = 4'hc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         if (n > 1) @(negedge clk);
         if (n == 2) begin
            in1 = 4'h0; in2 = 4'h2; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               lat = n; so = out; sx = x;
            end
         end
      end
      total++;
      if (ndone !== 1) begin
         bad++;
         $display("FAIL ignored_start done_count: got %0d need 1", ndone);
      end
      total++;
      if (lat !== m_lat(4'ha, 4'hc)) begin
         bad++;
         $display("FAIL ignored_start latency: got %0d need %0d", lat, m_lat(4'ha, 4'hc));
      end
      total++;
      if ({so, sx} !== {m_out(4'ha, 4'hc), m_x(4'ha, 4'hc)}) begin
         bad++;
         $display("FAIL ignored_start result: got out=%b x=%b need out=%b x=%b",
                  so, sx, m_out(4'ha, 4'hc), m_x(4'ha, 4'hc));
      end
   endtask

   task automatic test_reset_mid();
      int ndone = 0;
      int nbusy = 0;
      @(negedge clk);
      in1 = 4'h7; in2 = 4'h6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({busy, done, out, x} !== '0) begin
         bad++;
         $display("FAIL reset_mid immediate: got busy=%b done=%b out=%b x=%b need all 0",
                  busy, done, out, x);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (done) ndone++;
         if (busy) nbusy++;
      end
      total++;
      if ({ndone, nbusy} !== {32'd0, 32'd0}) begin
         bad++;
         $display("FAIL reset_mid after_release: got done=%0d busy=%0d cycles need 0 0", ndone, nbusy);
      end
      run_op(4'h7, 4'h6, "after_reset_7_6", 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] a, b;
         a = W'($urandom);
         b = W'($urandom);
         if ($urandom_range(0, 3) == 0) b = a;
         run_op(a, b, $sformatf("rand%0d", i), 1'b1);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] qa[$], qb[$];
      logic [1:0]   lo = '0;
      logic [W-1:0] lx = '0;
      int ndone = 0;
      int since = 0;
      int unstable = 0;
      int nlat = 0;
      logic [W-1:0] a, b;
      @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      in1 = a; in2 = b; start = 1'b1;
      qa.push_back(a); qb.push_back(b);
      for (int n = 0; n < 300 && ndone < 8; n++) begin
         @(negedge clk);
         since++;
         if (!done) begin
            if (ndone > 0 && {out, x} !== {lo, lx}) unstable++;
            continue;
         end
         a = qa.pop_front();
         b = qb.pop_front();
         nlat = m_lat(a, b);
         total++;
         if ({out, x} !== {m_out(a, b), m_x(a, b)}) begin
            bad++;
            $display("FAIL b2b%0d result: got out=%b x=%b need out=%b x=%b (a=%h b=%h)",
                     ndone, out, x, m_out(a, b), m_x(a, b), a, b);
         end
         if (ndone > 0) begin
            total++;
            if (since !== nlat + 1) begin
               bad++;
               $display("FAIL b2b%0d spacing: got %0d need %0d", ndone, since, nlat + 1);
            end
            total++;
            if (unstable !== 0) begin
               bad++;
               $display("FAIL b2b%0d stable: got %0d changed cycles need 0", ndone, unstable);
            end
         end
         lo = out; lx = x;
         since = 0; unstable = 0;
         ndone++;
         if (ndone < 8) begin
            a = ~in1; b = W'($urandom);
            if (ndone % 3 == 0) b = a;
            in1 = a; in2 = b;
            qa.push_back(a); qb.push_back(b);
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      total++;
      if (ndone !== 8) begin
         bad++;
         $display("FAIL b2b count: got %0d done pulses need 8", ndone);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ignored_start();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
